// File: rtl/uart_full_duplex.sv
// 8N1 UART: independent transmitter and receiver in a single clock domain.
// Bytes go out LSB first on tx. Bytes received on rx are presented on rx_data with rx_done.
`timescale 1ns/1ps
module uart_full_duplex #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] rx_data,
   output logic       tx_done,
   output logic       rx_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // Handshake: tx_start is accepted only while the transmitter is IDLE; tx_done
   // is a level that drops on acceptance and rises when the stop bit has ended.
   state_t           tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx       <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         case (tx_state)
            IDLE: begin
               tx     <= 1'b1;
               tx_cnt <= '0;
               tx_bit <= '0;
               if (tx_start) begin
                  tx_shift <= tx_data;
                  tx_done  <= 1'b0;
                  tx       <= 1'b0;
                  tx_state <= START;
               end
            end
            START: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx       <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= DATA;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt <= '0;
                  if (tx_bit == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= STOP;
                  end else begin
                     tx       <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            STOP: begin
               if (tx_cnt == CNT_LAST) begin
                  tx_cnt   <= '0;
                  tx_done  <= 1'b1;
                  tx_state <= IDLE;
               end else begin
                  tx_cnt <= tx_cnt + CNT_ONE;
               end
            end
            default: tx_state <= IDLE;
         endcase
      end
   end

   // Two-flop synchroniser; both flops idle high so reset does not fake a start bit.
   logic rx_s1, rx_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   state_t           rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_shift;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_done  <= 1'b0;
      end else begin
         case (rx_state)
            IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
               if (!rx_s2) begin
                  rx_done  <= 1'b0;
                  rx_state <= START;
               end
            end
            START: begin
               // Half-bit check aligns all later samples to bit centres.
               if (rx_cnt == CNT_HALF) begin
                  rx_cnt   <= '0;
                  rx_state <= rx_s2 ? IDLE : DATA;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            DATA: begin
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= STOP;
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            STOP: begin
               // Leaving at the stop-bit centre leaves half a bit to catch the next start.
               if (rx_cnt == CNT_LAST) begin
                  rx_cnt   <= '0;
                  rx_state <= IDLE;
                  if (rx_s2) begin
                     rx_data <= rx_shift;
                     rx_done <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + CNT_ONE;
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_full_duplex.sv
// Bench for uart_full_duplex: loopback frames checked against a byte-level model,
// plus glitch, framing-error and mid-frame reset cases driven on rx directly.
`timescale 1ns/1ps
module tb_uart_full_duplex;

   localparam int CPB = 50_000_000 / 115_200;

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       rx;
   logic       tx;
   logic [7:0] rx_data;
   logic       tx_done;
   logic       rx_done;

   logic       loop_en;
   logic       rx_ext;
   logic [7:0] exp_q[$];
   logic [7:0] last_rx;
   logic [7:0] exp_byte;
   logic       rx_done_q;
   int         total = 0;
   int         bad = 0;

   assign rx = loop_en ? tx : rx_ext;

   uart_full_duplex #(.CLK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .rx       (rx),
      .tx       (tx),
      .rx_data  (rx_data),
      .tx_done  (tx_done),
      .rx_done  (rx_done)
   );

   // clock / reset
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1'b1);
      check("reset_tx_done", tx_done, 1'b0);
      check("reset_rx_done", rx_done, 1'b0);
      check("reset_rx_data", rx_data, 8'h00);
      last_rx = 8'h00;
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Scoreboard monitor: every rising rx_done consumes one expected byte.
   always @(negedge clk) begin
      if (rx_done === 1'b1 && rx_done_q !== 1'b1 && reset !== 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
         end else begin
            exp_byte = exp_q.pop_front();
            check("rx_data", rx_data, exp_byte);
            last_rx = exp_byte;
         end
      end
      rx_done_q = rx_done;
   end

   // Driver: sends one byte in loopback and checks the serial waveform bit by bit.
   // Sample k is the negedge k cycles after the accepting clock edge.
   task automatic send(input logic [7:0] b, input bit poke);
      logic [9:0] frame;
      int         k;
      int         target;
      frame = {1'b1, b, 1'b0};
      exp_q.push_back(b);
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      k = 0;
      if (poke) begin
         fork
            begin
               repeat (3 * CPB) @(negedge clk);
               tx_data  = 8'h34;
               tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0;
            end
         join_none
      end
      @(negedge clk);
      k = 1;
      check("tx_done_clr", tx_done, 1'b0);
      repeat (CPB / 4 - k) @(negedge clk);
      k = CPB / 4;
      check("rx_done_clr", rx_done, 1'b0);
      for (int i = 0; i < 10; i++) begin
         target = i * CPB + CPB / 2;
         repeat (target - k) @(negedge clk);
         k = target;
         check($sformatf("tx_bit%0d", i), tx, frame[i]);
      end
      repeat (10 * CPB - 1 - k) @(negedge clk);
      check("tx_done_early", tx_done, 1'b0);
      @(negedge clk);
      check("tx_done_rise", tx_done, 1'b1);
   endtask

   // Watchdog
   initial begin
      #(200_000 * 20);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [9:0] bad_frame;
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      rx_ext    = 1'b1;
      loop_en   = 1'b1;
      reset     = 1'b1;
      rx_done_q = 1'b0;
      last_rx   = 8'h00;

      do_reset();

      send(8'hA5, 1'b0);
      repeat (4) @(negedge clk);
      send(8'h3C, 1'b0);
      repeat (4) @(negedge clk);
      send(8'hFF, 1'b0);
      repeat (4) @(negedge clk);

      send(8'h12, 1'b1);
      repeat (20) @(negedge clk);
      check("busy_one_frame_tx", tx, 1'b1);
      check("busy_one_frame_done", tx_done, 1'b1);
      check("busy_rx_data", rx_data, 8'h12);

      for (int n = 0; n < 4; n++) begin
         send(8'($urandom_range(0, 255)), 1'b0);
         repeat ($urandom_range(4, 30)) @(negedge clk);
      end
      check("queue_drain", exp_q.size(), 0);

      // RX faults with rx driven externally
      loop_en = 1'b0;
      rx_ext  = 1'b1;
      repeat (10) @(negedge clk);
      rx_ext = 1'b0;
      repeat (100) @(negedge clk);
      rx_ext = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check("glitch_rx_done", rx_done, 1'b0);
      check("glitch_rx_data", rx_data, last_rx);

      bad_frame = {1'b0, 8'h55, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_ext = bad_frame[i];
         repeat (CPB) @(negedge clk);
      end
      rx_ext = 1'b1;
      repeat (4) @(negedge clk);
      check("frame_err_rx_done", rx_done, 1'b0);
      check("frame_err_rx_data", rx_data, last_rx);

      // The low stop bit looks like a new start; reset clears that before loopback resumes.
      @(negedge clk);
      reset   = 1'b1;
      loop_en = 1'b1;
      do_reset();

      // Reset during TX data bits
      @(negedge clk);
      tx_data  = 8'h99;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_tx", tx, 1'b1);
      check("midreset_tx_done", tx_done, 1'b0);
      check("midreset_rx_done", rx_done, 1'b0);
      reset = 1'b0;
      repeat (10) @(negedge clk);

      send(8'hC3, 1'b0);
      repeat (20) @(negedge clk);
      check("final_queue_drain", exp_q.size(), 0);
      check("final_rx_data", rx_data, 8'hC3);
      check("final_rx_done", rx_done, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
